// File: rtl/switch_pkg.sv
// Shared switch definitions: egress read FSM states and packet header layout.
package switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN_WAIT,
    ST_PAYLOAD,
    ST_DRAIN
  } state_e;

  localparam int HDR_DA    = 0;
  localparam int HDR_SA    = 1;
  localparam int HDR_LEN   = 2;
  localparam int HDR_BYTES = 3;

endpackage

// File: rtl/egress_read_ctrl.sv
// Egress read controller: pulls DA,SA,LEN,payload out of a pointer-tracked FIFO.
// Optional `EGRESS_PKT_CNT_EN adds a 16-bit wrapping packet counter output pkt_cnt.
module egress_read_ctrl
  import switch_pkg::*;
#(
  parameter  int FIFO_SIZE = 64,
  parameter  int W_WIDTH   = 8,
  localparam int AW        = $clog2(FIFO_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      wr_pos,
  input  logic [AW-1:0]      rd_pos,
  input  logic [W_WIDTH-1:0] fifo_data,
  output logic               fifo_rd_en,
  input  logic               port_rd,
  output logic               port_ready,
  output logic               port_valid,
  output logic [W_WIDTH-1:0] port_data,
  output logic               port_eop
`ifdef EGRESS_PKT_CNT_EN
  ,
  output logic [15:0]        pkt_cnt
`endif
);

  state_e               state_q, state_d;
  logic [1:0]           hdr_cnt_q, hdr_cnt_d;
  logic [W_WIDTH-1:0]   remaining_q, remaining_d;
  logic                 port_valid_q;
  logic                 last_q, last_d;
  logic [AW-1:0]        occ;
  logic                 not_empty;
  logic                 rd_en;

  // Pointer wrap is absorbed by the modular subtraction.
  assign occ       = wr_pos - rd_pos;
  assign not_empty = (occ != '0);

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    remaining_d = remaining_q;
    last_d      = 1'b0;
    rd_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hdr_cnt_d = '0;
        if (port_rd && not_empty) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (not_empty) begin
          rd_en     = 1'b1;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'(HDR_LEN)) state_d = ST_LEN_WAIT;
        end
      end
      ST_LEN_WAIT: begin
        remaining_d = fifo_data;
        state_d     = (fifo_data == '0) ? ST_DRAIN : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (not_empty) begin
          rd_en       = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == W_WIDTH'(1)) begin
            last_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hdr_cnt_q    <= '0;
      remaining_q  <= '0;
      port_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      remaining_q  <= remaining_d;
      port_valid_q <= rd_en;
      last_q       <= last_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign port_valid = port_valid_q;
  assign port_data  = port_valid_q ? fifo_data : '0;
  // The LEN byte is on fifo_data exactly while in LEN_WAIT, so a zero length ends the packet there.
  assign port_eop   = port_valid_q &&
                      (last_q || ((state_q == ST_LEN_WAIT) && (fifo_data == '0)));
  assign port_ready = !rst && (state_q == ST_IDLE) && not_empty;

`ifdef EGRESS_PKT_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb pkt_cnt_d = pkt_cnt_q + 16'(port_eop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_cnt_q <= '0;
    else     pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule
